// File: rtl/seg_codes_pkg.sv
// seg_codes_pkg: display code constants, code type, converter FSM states
// and a constant power-of-ten helper shared by the bin2dec_digits slice.
package seg_codes_pkg;

    typedef logic [5:0] seg_code_t;

    localparam seg_code_t SEG_BLANK = 6'h3F;
    localparam seg_code_t SEG_E     = 6'h0E;
    localparam seg_code_t SEG_R     = 6'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FORMAT,
        ST_DONE
    } state_t;

    // Constant 10**n for elaboration-time limits.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/dd_digit_adj.sv
// dd_digit_adj: double-dabble nibble corrector. A nibble of 5 or more gets
// +3 so that the following left shift carries correctly into the next digit.
module dd_digit_adj (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    // Add 3 when the digit would reach 10 or more after doubling.
    always_comb begin
        o_nib = i_nib;
        if (i_nib >= 4'd5) o_nib = i_nib + 4'd3;
    end

endmodule

// File: rtl/bin2dec_digits.sv
// bin2dec_digits: sequential binary-to-decimal converter feeding six seg7
// decoders. One bit per cycle double-dabble, then a format pass producing a
// 6-bit display code per slot (digit, blank, or the "Err" overflow pattern).
// Optional leading-zero blanking is enabled by defining BIN2DEC_LZB_EN.
module bin2dec_digits
    import seg_codes_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [6*DIGITS-1:0]   digits,
    output logic                  overflow
);

    localparam int              NIB   = DIGITS + 1;
    localparam int              BCD_W = 4 * NIB;
    localparam int              CW    = $clog2(WIDTH + 1);
    localparam longint unsigned LIMIT = pow10(DIGITS);
    localparam longint unsigned MAXV  = (64'd1 << WIDTH) - 64'd1;

    // The BCD register must hold every representable input.
    generate
        if (MAXV >= pow10(DIGITS + 1)) begin : g_bad_width
            $error("bin2dec_digits: WIDTH too large for DIGITS+1 BCD nibbles");
        end
    endgenerate

    state_t                   r_state;
    logic [WIDTH-1:0]         r_shift;
    logic [BCD_W-1:0]         r_bcd;
    logic [CW-1:0]            r_cnt;
    logic                     r_ovf_pend;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_ovf;
    seg_code_t [DIGITS-1:0]   r_digits;

    logic [BCD_W-1:0]         w_adj;
    seg_code_t [DIGITS-1:0]   w_stage;
    logic                     w_ovf_in;

    assign w_ovf_in = 64'(value) >= LIMIT;

    for (genvar g = 0; g < NIB; g++) begin : g_adj
        dd_digit_adj u_adj (
            .i_nib (r_bcd[4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    // Map BCD nibbles to display codes; overflow replaces everything with Err.
    always_comb begin
`ifdef BIN2DEC_LZB_EN
        logic w_seen;
        w_seen = 1'b0;
`endif
        w_stage = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_stage[i] = {2'b00, r_bcd[4*i +: 4]};
`ifdef BIN2DEC_LZB_EN
            if (r_bcd[4*i +: 4] != 4'd0) w_seen = 1'b1;
            if (!w_seen && i != 0) w_stage[i] = SEG_BLANK;
`endif
        end
        if (r_ovf_pend) begin
            w_stage    = {DIGITS{SEG_BLANK}};
            w_stage[2] = SEG_E;
            w_stage[1] = SEG_R;
            w_stage[0] = SEG_R;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_digits   <= {DIGITS{SEG_BLANK}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift    <= value;
                        r_bcd      <= '0;
                        r_cnt      <= CW'(WIDTH - 1);
                        r_ovf_pend <= w_ovf_in;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_bcd   <= {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    // A bit leaving the top nibble can only mean the value
                    // did not fit; treat it as overflow rather than drop it.
                    r_ovf_pend <= r_ovf_pend | w_adj[BCD_W-1];
                    if (r_cnt == '0) r_state <= ST_FORMAT;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                ST_FORMAT: begin
                    r_digits <= w_stage;
                    r_ovf    <= r_ovf_pend;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign digits   = r_digits;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin2dec_digits.sv
// tb_bin2dec_digits: directed bench for bin2dec_digits with a latency-level
// reference model checked every cycle plus literal expectations.
module tb_bin2dec_digits;

    localparam int WIDTH  = 20;
    localparam int DIGITS = 6;
    localparam int LAT    = WIDTH + 2;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b1;
    logic              start   = 1'b0;
    logic [WIDTH-1:0]  value   = '0;
    logic              busy, done, overflow;
    logic [35:0]       digits;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ndone = 0;
    bit chk_en = 1'b0;

    localparam logic [35:0] ALL_BLANK = {6{6'h3F}};
    localparam logic [35:0] ERR_PAT   = {6'h3F, 6'h3F, 6'h3F, 6'h0E, 6'h10, 6'h10};
`ifdef BIN2DEC_LZB_EN
    localparam logic [35:0] EXP_ZERO = {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h00};
    localparam logic [35:0] EXP_42   = {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h04, 6'h02};
`else
    localparam logic [35:0] EXP_ZERO = {6{6'h00}};
    localparam logic [35:0] EXP_42   = {6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h02};
`endif

    bin2dec_digits #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected display codes straight from decimal arithmetic.
    function automatic logic [35:0] exp_digits(input int unsigned v);
        logic [35:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        if (v >= 32'd1000000) return ERR_PAT;
        for (int i = 0; i < 6; i++) begin
            r[6*i +: 6] = 6'((v / p) % 10);
            p = p * 10;
        end
`ifdef BIN2DEC_LZB_EN
        for (int i = 5; i > 0; i--) begin
            if (r[6*i +: 6] != 6'h00) break;
            r[6*i +: 6] = 6'h3F;
        end
`endif
        return r;
    endfunction

    // Reference model: a conversion is just a countdown of LAT cycles.
    int               m_left = 0;
    logic [WIDTH-1:0] m_val  = '0;
    logic [35:0]      m_dig  = {6{6'h3F}};
    logic             m_ovf  = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_left = 0;
                m_dig  = ALL_BLANK;
                m_ovf  = 1'b0;
            end else if (m_left == 0) begin
                if (start) begin
                    m_val  = value;
                    m_left = LAT;
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    m_dig = exp_digits(32'(m_val));
                    m_ovf = (m_val >= 20'd1000000);
                end
            end
        end
    end

    // Compare process: every cycle, all outputs against the model.
    initial begin
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("busy",     64'(busy),     64'(m_left > 0));
                chk("done",     64'(done),     64'(m_left == 1));
                chk("overflow", 64'(overflow), 64'(m_ovf));
                chk("digits",   64'(digits),   64'(m_dig));
                chk("done_back_to_back", 64'(done & prev_done), 64'd0);
                if (done === 1'b1) ndone++;
                prev_done = done;
            end
        end
    end

    task automatic conv(input logic [WIDTH-1:0] v, input string name);
        int t0;
        int lat;
        @(negedge clk);
        value = v;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        chk({name, "_latency"}, 64'(lat), 64'(LAT));
    endtask

    initial begin
        int t0;
        int d0;
        #1 reset_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_digits",   64'(digits),   64'(ALL_BLANK));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        conv(20'd123456, "v123456");
        chk("v123456_digits", 64'(digits), 64'({6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06}));
        chk("v123456_ovf", 64'(overflow), 64'd0);

        conv(20'd0, "v0");
        chk("v0_digits", 64'(digits), 64'(EXP_ZERO));

        conv(20'd999999, "v999999");
        chk("v999999_digits", 64'(digits), 64'({6{6'h09}}));
        chk("v999999_ovf", 64'(overflow), 64'd0);

        conv(20'd1000000, "v1000000");
        chk("v1000000_digits", 64'(digits), 64'(ERR_PAT));
        chk("v1000000_ovf", 64'(overflow), 64'd1);

        // Start during a conversion is dropped, not queued.
        @(negedge clk);
        d0 = ndone;
        value = 20'd42;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        value = 20'd777;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 60) @(negedge clk);
        chk("ignored_start_dones", 64'(ndone - d0), 64'd1);
        chk("v42_digits", 64'(digits), 64'(EXP_42));

        // Reset in the middle of a conversion.
        conv(20'd555555, "v555555");
        chk("v555555_digits", 64'(digits), 64'({6{6'h05}}));
        @(negedge clk);
        value = 20'd314159;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_digits",   64'(digits),   64'(ALL_BLANK));
        chk("abort_busy",     64'(busy),     64'd0);
        chk("abort_done",     64'(done),     64'd0);
        chk("abort_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        d0 = ndone;
        repeat (30) @(negedge clk);
        chk("abort_no_done", 64'(ndone - d0), 64'd0);
        conv(20'd314159, "v314159");
        chk("v314159_digits", 64'(digits), 64'({6'h03, 6'h01, 6'h04, 6'h01, 6'h05, 6'h09}));

        // Start held high: back-to-back Err results every WIDTH+3 cycles.
        @(negedge clk);
        value = 20'd1048575;
        start = 1'b1;
        t0 = cyc;
        d0 = ndone;
        while (cyc < t0 + 3 * (WIDTH + 3) + 2) @(negedge clk);
        start = 1'b0;
        chk("held_start_dones", 64'(ndone - d0), 64'd3);
        chk("held_digits", 64'(digits), 64'(ERR_PAT));
        chk("held_ovf", 64'(overflow), 64'd1);
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2dec_digits.md
# bin2dec_digits

Sequential binary-to-decimal converter that drives the six seven-segment decoders on the HEX displays. It accepts a binary value and converts it with a one-bit-per-cycle double-dabble engine. It then emits one 6-bit display code per digit, which each `seg7` instance consumes directly. Optional leading-zero blanking and an overflow "Err" pattern are handled here, so `seg7` stays purely combinational.

## Interface
- `WIDTH`, 20, width of the binary input; elaboration fails unless 2**WIDTH-1 < 10**(DIGITS+1)
- `DIGITS`, 6, number of output digit slots (one per HEX display)
- `clk`  input  1  system clock
- `reset_n`  input  1  reset; one clock, reset is asynchronous and active-low
- `start`  input  1  request conversion of `value`; sampled only in IDLE
- `value`  input  WIDTH  unsigned binary operand, captured when `start` is accepted
- `busy`  output  1  high from the cycle after acceptance until `done`, inclusive
- `done`  output  1  one-cycle pulse; `digits` and `overflow` are updated in the same cycle
- `digits`  output  6*DIGITS  display codes; bits [5:0] = ones digit (HEX0), [11:6] = tens, etc.
- `overflow`  output  1  last converted value was ≥ 10**DIGITS

## Operation
- FSM states: IDLE, SHIFT, FORMAT, DONE.
- IDLE:
  - `start`=1 captures `value` into the shift register and clears the internal BCD register (DIGITS+1 nibbles).
  - The FSM latches overflow_pending = (value ≥ 10**DIGITS) and moves to SHIFT.
- SHIFT, one cycle per bit (WIDTH cycles):
  - Every BCD nibble ≥ 5 gets +3.
  - The combined {bcd, shift} register then shifts left by 1, MSB first.
  - The bit counter counts WIDTH-1 down to 0; at 0 the FSM moves to FORMAT.
- FORMAT: each BCD nibble maps to code {2'b00, nibble}; the staging register is loaded.
  - With overflow_pending set: the low three slots get E(6'h0E), r(6'h10), r(6'h10), left to right (slot 2 = E, slot 0 = r), and all higher slots get blank (6'h3F). `overflow` will read 1.
- DONE: staging is copied to `digits` and `overflow`, `done`=1, and the FSM returns to IDLE.
- `start` while not in IDLE is ignored. It is not queued.
- `digits` and `overflow` hold their previous result until the next DONE. There are no intermediate values.
- Reset values: `busy`=0, `done`=0, `overflow`=0, every `digits` slot = 6'h3F (blank), FSM = IDLE.
- Reset mid-conversion aborts immediately to reset values; the partial result is discarded.
- Value 0: the ones slot shows 6'h00. Higher slots follow the blanking rule in Configuration.

## Timing
- Cycle N: `start` sampled high in IDLE.
- Cycles N+1 … N+WIDTH: SHIFT (`busy`=1).
- Cycle N+WIDTH+1: FORMAT.
- Cycle N+WIDTH+2: DONE; `done`=1, new `digits` visible. Latency is 22 cycles at the default WIDTH.
- Earliest next acceptance: cycle N+WIDTH+3 (`start` held high restarts back-to-back).
- `busy` deasserts in the cycle after `done`.
- All outputs are registered. `seg7` adds only combinational delay.

## Configuration
- `BIN2DEC_LZB_EN` defined:
  - In FORMAT, leading zeros above the most significant nonzero digit become 6'h3F.
  - The ones digit is never blanked.
  - The Err pattern is unaffected.
- Undefined: all non-overflow slots show their digit, including leading zeros (0 → six 6'h00).

## Structure
- Package `seg_codes_pkg`:
  - Code constants SEG_BLANK=6'h3F, SEG_E=6'h0E, SEG_R=6'h10.
  - `seg_code_t` (logic [5:0]).
  - FSM state enum.
- Sub-module `dd_digit_adj`: combinational nibble corrector (in ≥ 5 → in+3), instantiated DIGITS+1 times.
- The top level holds the FSM, counter, shift/BCD registers and format logic.

## Test plan
- `value`=123456, `start` pulse at cycle N → `done` exactly at N+22 with slots 5..0 = 01,02,03,04,05,06; `overflow`=0; `busy` high N+1..N+22.
- `value`=0 → with `BIN2DEC_LZB_EN` slots = 3F,3F,3F,3F,3F,00; without it, all 00.
- `value`=999999 → all slots 09, `overflow`=0. `value`=1000000 → slots 3F,3F,3F,0E,10,10, `overflow`=1.
- `value`=42 started, then `start` with 777 at N+5 → only one `done` (at N+22), showing 42. No second conversion follows.
- Convert 555555, then assert `reset_n`=0 at N+10 of a 314159 conversion → outputs immediately all 3F, `busy`=0, no `done`. A fresh start afterwards converts correctly.
- `start` held high continuously with `value`=1048575 → Err result every WIDTH+3 cycles, `done` never high two cycles in a row.
